// File: rtl/display_pkg.sv
// Shared constants and types for the frame-buffer scan-out path.
// Raster geometry of a 100x100 active image with porches and sync widths.
package display_pkg;

    localparam int H_ACTIVE = 100;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 100;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int BUF_DEPTH = 10000;
    localparam int ADDR_W    = 20;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/raster_timing.sv
// Horizontal/vertical raster counters with active-region, sync and frame strobes.
// Counters sit at zero while run is low so a new frame always starts at the origin.
module raster_timing #(
    parameter int H_ACTIVE = display_pkg::H_ACTIVE,
    parameter int H_FP     = display_pkg::H_FP,
    parameter int H_SYNC   = display_pkg::H_SYNC,
    parameter int H_BP     = display_pkg::H_BP,
    parameter int V_ACTIVE = display_pkg::V_ACTIVE,
    parameter int V_FP     = display_pkg::V_FP,
    parameter int V_SYNC   = display_pkg::V_SYNC,
    parameter int V_BP     = display_pkg::V_BP
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic sof,
    output logic eof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (hcnt == HW'(H_TOTAL - 1));
    assign v_last = (vcnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign active = run && (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    assign hsync  = !((hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync  = !((vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign sof    = active && (hcnt == '0) && (vcnt == '0);
    assign eof    = run && h_last && v_last;

endmodule

// File: rtl/buf_scanout.sv
// Scan-out controller: reads the displayed frame buffer in raster order and aligns
// returned pixels with sync/data-enable; buffer swaps happen only at frame end.
module buf_scanout
    import display_pkg::ADDR_W, display_pkg::rgb_t, display_pkg::scan_state_t,
           display_pkg::ST_IDLE, display_pkg::ST_RUN;
#(
    parameter int H_ACTIVE = display_pkg::H_ACTIVE,
    parameter int H_FP     = display_pkg::H_FP,
    parameter int H_SYNC   = display_pkg::H_SYNC,
    parameter int H_BP     = display_pkg::H_BP,
    parameter int V_ACTIVE = display_pkg::V_ACTIVE,
    parameter int V_FP     = display_pkg::V_FP,
    parameter int V_SYNC   = display_pkg::V_SYNC,
    parameter int V_BP     = display_pkg::V_BP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              sel,
    output logic              re0,
    output logic              re1,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        r0,
    input  logic [7:0]        g0,
    input  logic [7:0]        b0,
    input  logic [7:0]        r1,
    input  logic [7:0]        g1,
    input  logic [7:0]        b1,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);

    scan_state_t       state, state_nxt;
    logic              run;
    logic              vld_p0, hsync_p0, vsync_p0, sof_p0, eof;
    logic [ADDR_W-1:0] pix_idx;
    logic              vld_p1, hsync_p1, vsync_p1, sof_p1, sel_p1;
    rgb_t              buf0_pix, buf1_pix, pix_p1;
    logic              vld_p2, hsync_p2, vsync_p2, sof_p2;
    rgb_t              pix_p2;

    raster_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .active (vld_p0),
        .hsync  (hsync_p0),
        .vsync  (vsync_p0),
        .sof    (sof_p0),
        .eof    (eof)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Leaving RUN waits for the frame to finish so the display never sees a torn frame.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en)         state_nxt = ST_RUN;
            ST_RUN:  if (eof && !en) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        run = (state == ST_RUN);
    end

    // Stage 0: read address and buffer select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_idx  <= '0;
            sel      <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= eof && swap_req;
            if (eof) begin
                pix_idx <= '0;
                if (swap_req) sel <= !sel;
            end else if (vld_p0) begin
                pix_idx <= pix_idx + 1'b1;
            end
        end
    end

    assign rd_addr = pix_idx;
    assign re0     = vld_p0 && !sel;
    assign re1     = vld_p0 && sel;

    // Stage 1: buffer data valid; sel travels with it so in-flight pixels keep their source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            sof_p1   <= 1'b0;
            sel_p1   <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
            sof_p1   <= sof_p0;
            sel_p1   <= sel;
        end
    end

    assign buf0_pix = {r0, g0, b0};
    assign buf1_pix = {r1, g1, b1};
    assign pix_p1   = !vld_p1 ? '0 : (sel_p1 ? buf1_pix : buf0_pix);

    // Stage 2: registered pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_p2   <= '0;
            vld_p2   <= 1'b0;
            hsync_p2 <= 1'b1;
            vsync_p2 <= 1'b1;
            sof_p2   <= 1'b0;
        end else begin
            pix_p2   <= pix_p1;
            vld_p2   <= vld_p1;
            hsync_p2 <= hsync_p1;
            vsync_p2 <= vsync_p1;
            sof_p2   <= sof_p1;
        end
    end

    assign vga_r       = pix_p2.r;
    assign vga_g       = pix_p2.g;
    assign vga_b       = pix_p2.b;
    assign de          = vld_p2;
    assign hsync       = hsync_p2;
    assign vsync       = vsync_p2;
    assign frame_start = sof_p2;

endmodule

// File: tb/tb_buf_scanout.sv
// Bench for buf_scanout: start-up vector table, then frame-level scenarios checked
// every cycle against a position-based raster model with two buffer models.
module tb_buf_scanout;

    localparam int HT = 116;
    localparam int VT = 106;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset, en, swap_req;
    logic        swap_ack, sel, re0, re1;
    logic [19:0] rd_addr;
    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, de, frame_start;

    logic [23:0] mem1 [0:16383];
    logic [23:0] q0 = '0;
    logic [23:0] q1 = '0;

    always #5 clk = ~clk;

    buf_scanout dut (
        .clk(clk), .reset(reset), .en(en), .swap_req(swap_req),
        .swap_ack(swap_ack), .sel(sel), .re0(re0), .re1(re1), .rd_addr(rd_addr),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    // Frame buffers: one-cycle read latency, hold when not read.
    always @(posedge clk) begin
        if (re0) q0 <= {4'b0, rd_addr};
        if (re1) q1 <= mem1[rd_addr[13:0]];
    end
    assign {r0, g0, b0} = q0;
    assign {r1, g1, b1} = q1;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame position p, pixel index computed as v*100+h.
    typedef struct packed {
        logic        de, hs, vs, fs;
        logic [23:0] rgb;
    } pin_t;

    localparam pin_t PIN_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 24'h0};

    bit   m_run;
    int   m_p;
    logic m_sel, m_ack;
    pin_t d1, d2;

    function automatic void model_reset();
        m_run = 0; m_p = 0; m_sel = 0; m_ack = 0;
        d1 = PIN_IDLE; d2 = PIN_IDLE;
    endfunction

    function automatic logic [23:0] buf_word(input logic s, input int idx);
        logic [23:0] w;
        w = s ? mem1[idx[13:0]] : idx[23:0];
        return w;
    endfunction

    function automatic void model_step();
        int h, v;
        bit act;
        pin_t c;
        h = m_p % HT;
        v = m_p / HT;
        act = m_run && h < 100 && v < 100;
        c.de  = act;
        c.hs  = !(h >= 104 && h <= 111);
        c.vs  = !(v >= 102 && v <= 103);
        c.fs  = m_run && m_p == 0;
        c.rgb = act ? buf_word(m_sel, v * 100 + h) : 24'h0;
        d2 = d1;
        d1 = c;
        m_ack = 0;
        if (m_run) begin
            if (m_p == FT - 1) begin
                if (swap_req) begin
                    m_sel = !m_sel;
                    m_ack = 1;
                end
                m_run = en;
                m_p = 0;
            end else begin
                m_p++;
            end
        end else if (en) begin
            m_run = 1;
            m_p = 0;
        end
        cyc++;
    endfunction

    // Trackers for frame-level properties.
    int  fs_count = 0, fs_cyc = 0, decnt = 0, ack_cnt = 0;
    int  line_de_cyc = 0, hl = 0, vl = 0, hruns = 0, vruns = 0, hoffs = 0;
    logic prev_de = 0, prev_hs = 1;

    task automatic check_model();
        int h, v;
        bit act;
        h = m_p % HT;
        v = m_p / HT;
        act = m_run && h < 100 && v < 100;
        chk("re0", re0, act && !m_sel);
        chk("re1", re1, act && m_sel);
        if (act || !m_run) chk("rd_addr", rd_addr, act ? v * 100 + h : 0);
        chk("sel", sel, m_sel);
        chk("swap_ack", swap_ack, m_ack);
        chk("de", de, d2.de);
        chk("hsync", hsync, d2.hs);
        chk("vsync", vsync, d2.vs);
        chk("frame_start", frame_start, d2.fs);
        chk("vga_rgb", {vga_r, vga_g, vga_b}, d2.rgb);

        if (swap_ack) ack_cnt++;
        if (frame_start) begin
            fs_count++;
            if (fs_count == 2 || fs_count == 3) chk("de_per_frame", decnt, 10000);
            if (fs_count == 2) chk("frame_period", cyc - fs_cyc, FT);
            fs_cyc = cyc;
            decnt = 0;
        end
        if (de) begin
            if (fs_count == 1 && (decnt % 1111 == 0 || decnt == 9999))
                chk("kth_pixel", {vga_r, vga_g, vga_b}, decnt);
            decnt++;
        end
        if (de && !prev_de) line_de_cyc = cyc;
        if (prev_hs && !hsync && hoffs < 5) begin
            chk("hsync_offset", cyc - line_de_cyc, 104);
            hoffs++;
        end
        if (!hsync) hl++;
        else if (hl > 0) begin
            if (hruns < 5) chk("hsync_width", hl, 8);
            hruns++;
            hl = 0;
        end
        if (!vsync) vl++;
        else if (vl > 0) begin
            if (vruns < 2) chk("vsync_width", vl, 232);
            vruns++;
            vl = 0;
        end
        prev_de = de;
        prev_hs = hsync;
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic step(input logic en_v, input logic req_v);
        en = en_v;
        swap_req = req_v;
        model_step();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_hsync"}, hsync, 1);
        chk({tag, "_vsync"}, vsync, 1);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        chk({tag, "_re0"}, re0, 0);
        chk({tag, "_re1"}, re1, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_swap_ack"}, swap_ack, 0);
        chk({tag, "_sel"}, sel, 0);
    endtask

    typedef struct {
        logic        en;
        logic        re0;
        logic [19:0] addr;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int   t_req, n_run;
        logic req_state, got_ack, en_v, dropped;

        tbl[0] = '{en: 1'b1, re0: 1'b0, addr: 20'd0, de: 1'b0, fs: 1'b0, rgb: 24'd0};
        tbl[1] = '{en: 1'b1, re0: 1'b1, addr: 20'd0, de: 1'b0, fs: 1'b0, rgb: 24'd0};
        tbl[2] = '{en: 1'b1, re0: 1'b1, addr: 20'd1, de: 1'b0, fs: 1'b0, rgb: 24'd0};
        tbl[3] = '{en: 1'b1, re0: 1'b1, addr: 20'd2, de: 1'b1, fs: 1'b1, rgb: 24'd0};
        tbl[4] = '{en: 1'b1, re0: 1'b1, addr: 20'd3, de: 1'b1, fs: 1'b0, rgb: 24'd1};
        tbl[5] = '{en: 1'b1, re0: 1'b1, addr: 20'd4, de: 1'b1, fs: 1'b0, rgb: 24'd2};

        for (int i = 0; i < 16384; i++) mem1[i] = 24'($urandom);

        reset = 1'b0;
        en = 1'b0;
        swap_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks("por");
        reset = 1'b1;

        // Start-up vectors.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tbl_re0", re0, tbl[i].re0);
            chk("tbl_re1", re1, 0);
            chk("tbl_addr", rd_addr, tbl[i].addr);
            chk("tbl_de", de, tbl[i].de);
            chk("tbl_fs", frame_start, tbl[i].fs);
            chk("tbl_rgb", {vga_r, vga_g, vga_b}, tbl[i].rgb);
            check_model();
            step(tbl[i].en, 1'b0);
        end

        // Frame 1 from buffer 0; swap requested at a random mid-frame point.
        t_req = $urandom_range(1000, 11000);
        req_state = 0;
        got_ack = 0;
        for (int i = 0; i < 13000 && !got_ack; i++) begin
            tick();
            if (req_state && swap_ack) begin
                req_state = 0;
                got_ack = 1;
            end
            if (i == t_req) req_state = 1;
            step(1'b1, req_state);
        end
        chk("swap_ack_seen", got_ack, 1);

        // Frame 2 from buffer 1; enable dropped at pixel 5000.
        en_v = 1;
        dropped = 0;
        for (int i = 0; i < 13000 && (m_run || i == 0); i++) begin
            tick();
            if (re1 && rd_addr == 20'd5000) begin
                en_v = 0;
                dropped = 1;
            end
            step(en_v, 1'b0);
        end
        chk("en_drop_seen", dropped, 1);

        // Idle: requests must be ignored, nothing read or displayed.
        for (int i = 0; i < 300; i++) begin
            tick();
            step(1'b0, 1'($urandom_range(0, 1)));
        end

        // Partial frame 3 with random request noise away from the frame end.
        n_run = $urandom_range(1500, 3000);
        for (int i = 0; i < n_run; i++) begin
            tick();
            step(1'b1, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 200 && !de; i++) begin
            tick();
            step(1'b1, 1'b0);
        end
        chk("pre_reset_de", de, 1);
        chk("pre_reset_sel", sel, 1);

        // Asynchronous reset mid-line.
        #2 reset = 1'b0;
        #1 reset_checks("async");
        model_reset();
        en = 1'b0;
        swap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            step(1'b1, 1'b0);
        end

        chk("ack_pulses", ack_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
